// File: rtl/chunked_adder_if.sv
// Operand/result handshake bundle for chunked_adder_seq.
// CHUNKED_ADDER_OVF_EN adds the signed-overflow flag alongside cout.
interface chunked_adder_if #(
    parameter int WIDTH = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef CHUNKED_ADDER_OVF_EN
    logic             ovf;
`endif

    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef CHUNKED_ADDER_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, cout, busy
    );

    modport master (
`ifdef CHUNKED_ADDER_OVF_EN
        input  ovf,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/chunked_adder_seq.sv
// Multi-cycle WIDTH-bit adder, one CHUNK-bit ripple slice per clock, LSB slice first.
// Optional macro CHUNKED_ADDER_OVF_EN adds a registered two's-complement overflow flag.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for operands, in_ready high
// RUN    | one slice per edge, carry chained through carry_q
// DONE   | result held with out_valid high until out_ready
module chunked_adder_seq #(
    parameter int WIDTH = 12,
    parameter int CHUNK = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    chunked_adder_if.slave   bus_s
);
    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
        $error("chunked_adder_seq: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [CHUNK-1:0]   a_sl;
    logic [CHUNK-1:0]   b_sl;
    logic [CHUNK:0]     t_sl;
    logic               slice_ovf;
    int                 off;

    // Slice datapath: CHUNK+1 bit add so the top bit is the slice carry out
    always_comb begin
        off  = int'(idx_q) * CHUNK;
        a_sl = a_q[off +: CHUNK];
        b_sl = b_q[off +: CHUNK];
        t_sl = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
        // carry into the slice MSB is recovered from the MSB sum bit
        slice_ovf = (a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ t_sl[CHUNK-1]) ^ t_sl[CHUNK];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus_s.in_valid) begin
                    a_d     = bus_s.a;
                    b_d     = bus_s.b;
                    carry_d = bus_s.cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[off +: CHUNK] = t_sl[CHUNK-1:0];
                carry_d             = t_sl[CHUNK];
                if (idx_q == IDX_LAST) begin
                    cout_d  = t_sl[CHUNK];
                    ovf_d   = slice_ovf;
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus_s.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign bus_s.in_ready  = (state_q == S_IDLE);
    assign bus_s.out_valid = (state_q == S_DONE);
    assign bus_s.busy      = (state_q != S_IDLE);
    assign bus_s.sum       = sum_q;
    assign bus_s.cout      = cout_q;

`ifdef CHUNKED_ADDER_OVF_EN
    assign bus_s.ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q ^ slice_ovf;
`endif

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Self-checking bench for chunked_adder_seq (WIDTH=12, CHUNK=3): directed cases plus
// randomized ops with stalls, checked against a plain a+b+cin reference.
module tb_chunked_adder_seq;
    localparam int WIDTH = 12;
    localparam int CHUNK = 3;
    localparam int N     = WIDTH / CHUNK;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    chunked_adder_if #(.WIDTH(WIDTH)) bus ();

    chunked_adder_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_s (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ref_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    task automatic check_ovf(input string tag, input logic exp);
`ifdef CHUNKED_ADDER_OVF_EN
        check(tag, 32'(bus.ovf), 32'(exp));
`endif
    endtask

    // Accept one op, measure latency, hold result for `stall` cycles, then drain.
    // With noise set, in_valid/operands/out_ready toggle randomly while busy.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                          input int stall, input bit noise, input string tag);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] es;
        logic             ec;
        logic             eo;
        int               lat;
        bit               seen;
        full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        es   = full[WIDTH-1:0];
        ec   = full[WIDTH];
        eo   = ref_ovf(a, b, es);

        check({tag, "_ready_before"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
        tick();
        bus.in_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k < 3 * N && !seen; k++) begin
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            check({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
            if (noise) begin
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.a         = WIDTH'($urandom);
                bus.b         = WIDTH'($urandom);
                bus.cin       = 1'($urandom_range(0, 1));
                bus.out_ready = 1'($urandom_range(0, 1));
            end
            tick();
            lat++;
            if (bus.out_valid) seen = 1'b1;
        end
        bus.out_ready = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(N));
        if (!seen) begin
            bus.in_valid = 1'b0;
            return;
        end
        for (int k = 0; k <= stall; k++) begin
            check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
            check({tag, "_sum"}, 32'(bus.sum), 32'(es));
            check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
            check_ovf({tag, "_ovf"}, eo);
            if (k < stall) tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        #22;
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check_ovf("rst_ovf", 1'b0);
        rst_n = 1'b1;
        #3;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        tick();

        run_op(12'h123, 12'h456, 1'b0, 0, 1'b0, "basic");
        run_op(12'hFFF, 12'h001, 1'b0, 0, 1'b0, "ripple");
        run_op(12'h7FF, 12'h001, 1'b0, 0, 1'b0, "sovf");
        run_op(12'hFFF, 12'hFFF, 1'b1, 5, 1'b0, "stall");

        // reset mid-RUN after two slices
        bus.in_valid = 1'b1;
        bus.a        = 12'hABC;
        bus.b        = 12'h987;
        bus.cin      = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("midrun_busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_sum", 32'(bus.sum), 32'd0);
        check("midrst_cout", 32'(bus.cout), 32'd0);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check_ovf("midrst_ovf", 1'b0);
        #4;
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        run_op(12'h001, 12'h002, 1'b1, 0, 1'b0, "post_rst");

        for (int i = 0; i < 500; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                   1'b1, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
